mem_result_checker: RTL and testbench
=====================================

// Module: mem_result_checker
// PURPOSE
//  Stage downstream of the floyd_warshall HIR/HLS pair in the co-simulation bench.
//  Watches both DUTs' memory write strobes and waits until both go quiet.
//  Then scans the two result memories (A = HIR, B = HLS) address by address
//  through their 1-cycle-latency read ports. Reports pass/fail, mismatch count
//  and first-mismatch details. Replaces manual waveform diffing of path_mem.
// PARAMETERS
//  WIDTH         32      data width of each memory word
//  SIZE          64      words per memory; scan covers 0..SIZE-1
//  ADDR_W        6       address width, = $clog2(SIZE)
//  IDLE_TIMEOUT  16      consecutive write-free cycles that end RUN
//  MAX_CYCLES    65536   RUN watchdog limit in cycles
//  CNT_W         16      width of the write and mismatch counters
// PORTS
//  clk                  in   1       bench clock
//  rst                  in   1       synchronous, active-high reset
//  tstart               in   1       1-cycle start pulse, same as the one given to the DUTs
//  a_wr_en              in   1       write strobe of memory A
//  b_wr_en              in   1       write strobe of memory B
//  a_rd_en / b_rd_en    out  1       read enables to memories A and B
//  a_rd_addr/b_rd_addr  out  ADDR_W  read addresses; A and B always carry the same value
//  a_rd_data/b_rd_data  in   WIDTH   read data, valid the cycle after rd_en
//  done                 out  1       check complete; held high in DONE
//  pass                 out  1       valid only while done=1
//  timeout              out  1       RUN watchdog expired
//  late_write           out  1       a write was seen during SCAN
//  a_wr_cnt / b_wr_cnt  out  CNT_W   writes seen in RUN; saturating
//  mismatch_cnt         out  CNT_W   words that differ; saturating
//  first_mm_addr        out  ADDR_W  address of the first mismatch
//  first_mm_a/first_mm_b out WIDTH   A and B data at the first mismatch
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; internal counters 0.
//    rst mid-operation aborts at once: rd_en=0 on the cycle after the rst edge.
//  States: IDLE -> RUN -> SCAN -> DRAIN -> DONE; DONE -> RUN on tstart.
//  IDLE/DONE + tstart:
//    clear counters, flags and first_mm_*; done=0; go to RUN.
//    The write strobes of the tstart cycle itself are not counted.
//  RUN:
//    a_wr_cnt/b_wr_cnt +1 per cycle their wr_en is high; both may count in one cycle.
//    idle_cnt clears on any wr_en, else increments.
//    idle_cnt == IDLE_TIMEOUT-1 with no write this cycle -> SCAN.
//    A DUT that never writes is legal.
//    run_cnt == MAX_CYCLES-1 -> timeout=1, go to DONE; no scan is performed.
//    If idle and watchdog fire together, the watchdog wins.
//  SCAN:
//    rd_en=1 on both ports; addr runs 0..SIZE-1, one word per cycle.
//    Address is registered with a valid bit for the compare one cycle later.
//    After issuing SIZE-1 -> DRAIN.
//  Compare (cycle after each read):
//    a_rd_data != b_rd_data -> mismatch_cnt+1.
//    first_mm_* captured only when mismatch_cnt was 0.
//  DRAIN: rd_en=0; the final compare happens here; next state DONE.
//    SCAN entry to done=1 takes SIZE+1 cycles.
//  DONE:
//    done=1; pass = (mismatch_cnt==0) & !timeout & !late_write.
//    Outputs are held until rst or tstart.
//  Any wr_en during SCAN/DRAIN -> late_write=1; this is sticky.
//  tstart in RUN/SCAN/DRAIN is ignored.
//  All counters saturate at all-ones with no wrap.
//    The compare runs on the full WIDTH; no sign interpretation.
// TESTING
//  1. Identical memories; A pulses wr_en 10x, B 12x, then both idle
//     -> SCAN 16 cycles after the last write; done 65 cycles later;
//        pass=1, a_wr_cnt=10, b_wr_cnt=12.
//  2. A[32]=0, B[32]=33, rest equal -> mismatch_cnt=1, first_mm_addr=32,
//     first_mm_a=0, first_mm_b=33, pass=0.
//  3. Differences at 5 and 60 -> mismatch_cnt=2, first_mm_addr=5.
//  4. a_wr_en held high with MAX_CYCLES=100 -> timeout=1, done after 100 RUN cycles,
//     pass=0, rd_en never asserted.
//  5. b_wr_en pulse at SCAN address 20 -> late_write=1, pass=0 even with equal data.
//  6. rst mid-SCAN -> rd_en=0 and done=0 next cycle; a new tstart reruns
//     scenario 1 with pass=1.

Source files
------------

// File: rtl/mem_result_checker_if.sv
// mem_result_checker_if
//   Connects the result checker to two result memories, A and B.
//   Carries write strobes that the checker watches, and one read port per memory.
//   Parameters:
//     WIDTH  - data width of each memory word
//     ADDR_W - read address width
//   Signals:
//     a_wr_en, b_wr_en     - memory write strobes, observed by the checker
//     a_rd_en, b_rd_en     - read enables, driven by the checker
//     a_rd_addr, b_rd_addr - read addresses, driven by the checker
//     a_rd_data, b_rd_data - read data, valid one cycle after rd_en
//   Modports:
//     master - checker side
//     slave  - memory side
interface mem_result_checker_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              a_wr_en;
  logic              b_wr_en;
  logic              a_rd_en;
  logic              b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [WIDTH-1:0]  a_rd_data;
  logic [WIDTH-1:0]  b_rd_data;

  modport master (
    input  a_wr_en, b_wr_en, a_rd_data, b_rd_data,
    output a_rd_en, b_rd_en, a_rd_addr, b_rd_addr
  );

  modport slave (
    output a_wr_en, b_wr_en, a_rd_data, b_rd_data,
    input  a_rd_en, b_rd_en, a_rd_addr, b_rd_addr
  );
endinterface

// File: rtl/mem_result_checker.sv
// mem_result_checker
//   Compares the result memories of two implementations (A = HIR, B = HLS).
//   After tstart it counts the write strobes of each memory until both have
//   been quiet for IDLE_TIMEOUT cycles. It then reads both memories word by
//   word and compares them. It reports pass/fail, the mismatch count, and the
//   details of the first mismatch. A watchdog ends a run that never goes quiet.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     tstart        - one-cycle start pulse
//     mem           - memory interface (write strobes in, read ports out/in)
//     done          - check complete, held until rst or tstart
//     pass          - result, meaningful only while done=1
//     timeout       - watchdog expired during RUN
//     late_write    - a write arrived while the memories were being scanned
//     a_wr_cnt      - saturating count of memory A writes during RUN
//     b_wr_cnt      - saturating count of memory B writes during RUN
//     mismatch_cnt  - saturating count of words that differ
//     first_mm_addr - address of the first mismatch
//     first_mm_a    - memory A data at the first mismatch
//     first_mm_b    - memory B data at the first mismatch
module mem_result_checker #(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 64,
  parameter int ADDR_W       = 6,
  parameter int IDLE_TIMEOUT = 16,
  parameter int MAX_CYCLES   = 65536,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tstart,
  mem_result_checker_if.master mem,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              late_write,
  output logic [CNT_W-1:0]  a_wr_cnt,
  output logic [CNT_W-1:0]  b_wr_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_mm_addr,
  output logic [WIDTH-1:0]  first_mm_a,
  output logic [WIDTH-1:0]  first_mm_b
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int RUN_W  = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              rd_en;
  logic              any_wr;
  logic              idle_hit;
  logic              run_hit;
  logic [IDLE_W-1:0] idle_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [ADDR_W-1:0] scan_addr;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;

  assign any_wr   = mem.a_wr_en | mem.b_wr_en;
  assign idle_hit = !any_wr && (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
  assign run_hit  = (run_cnt == RUN_W'(MAX_CYCLES - 1));

  assign mem.a_rd_en   = rd_en;
  assign mem.b_rd_en   = rd_en;
  assign mem.a_rd_addr = scan_addr;
  assign mem.b_rd_addr = scan_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (tstart) state_nx = RUN;
      end
      RUN: begin
        // The watchdog takes priority over the quiet-period exit.
        if (run_hit)       state_nx = DONE;
        else if (idle_hit) state_nx = SCAN;
      end
      SCAN: begin
        rd_en = 1'b1;
        if (scan_addr == ADDR_W'(SIZE - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (tstart) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pass = done && (mismatch_cnt == '0) && !timeout && !late_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt      <= '0;
      run_cnt       <= '0;
      scan_addr     <= '0;
      cmp_valid     <= 1'b0;
      cmp_addr      <= '0;
      timeout       <= 1'b0;
      late_write    <= 1'b0;
      a_wr_cnt      <= '0;
      b_wr_cnt      <= '0;
      mismatch_cnt  <= '0;
      first_mm_addr <= '0;
      first_mm_a    <= '0;
      first_mm_b    <= '0;
    end else begin
      // Read data returns one cycle after the request, so the address is
      // delayed alongside a valid bit to line up with it.
      cmp_valid <= rd_en;
      cmp_addr  <= scan_addr;

      case (state)
        IDLE, DONE: begin
          if (tstart) begin
            idle_cnt      <= '0;
            run_cnt       <= '0;
            scan_addr     <= '0;
            timeout       <= 1'b0;
            late_write    <= 1'b0;
            a_wr_cnt      <= '0;
            b_wr_cnt      <= '0;
            mismatch_cnt  <= '0;
            first_mm_addr <= '0;
            first_mm_a    <= '0;
            first_mm_b    <= '0;
          end
        end
        RUN: begin
          if (mem.a_wr_en && (a_wr_cnt != '1)) a_wr_cnt <= a_wr_cnt + CNT_W'(1);
          if (mem.b_wr_en && (b_wr_cnt != '1)) b_wr_cnt <= b_wr_cnt + CNT_W'(1);
          idle_cnt  <= any_wr ? '0 : idle_cnt + IDLE_W'(1);
          run_cnt   <= run_cnt + RUN_W'(1);
          scan_addr <= '0;
          if (run_hit) timeout <= 1'b1;
        end
        SCAN: begin
          scan_addr <= scan_addr + ADDR_W'(1);
          if (any_wr) late_write <= 1'b1;
        end
        DRAIN: begin
          if (any_wr) late_write <= 1'b1;
        end
        default: ;
      endcase

      if (cmp_valid && (mem.a_rd_data != mem.b_rd_data)) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (mismatch_cnt == '0) begin
          first_mm_addr <= cmp_addr;
          first_mm_a    <= mem.a_rd_data;
          first_mm_b    <= mem.b_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_result_checker.sv
module tb_mem_result_checker;
  localparam int WIDTH        = 32;
  localparam int SIZE         = 64;
  localparam int ADDR_W       = 6;
  localparam int IDLE_TIMEOUT = 16;
  localparam int MAX_CYCLES   = 100;
  localparam int CNT_W        = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tstart = 1'b0;
  logic              done, pass, timeout, late_write;
  logic [CNT_W-1:0]  a_wr_cnt, b_wr_cnt, mismatch_cnt;
  logic [ADDR_W-1:0] first_mm_addr;
  logic [WIDTH-1:0]  first_mm_a, first_mm_b;

  mem_result_checker_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) mem ();

  mem_result_checker #(
    .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tstart(tstart), .mem(mem),
    .done(done), .pass(pass), .timeout(timeout), .late_write(late_write),
    .a_wr_cnt(a_wr_cnt), .b_wr_cnt(b_wr_cnt), .mismatch_cnt(mismatch_cnt),
    .first_mm_addr(first_mm_addr), .first_mm_a(first_mm_a), .first_mm_b(first_mm_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Result memories with a 1-cycle read latency.
  logic [WIDTH-1:0] mem_a [SIZE];
  logic [WIDTH-1:0] mem_b [SIZE];
  always @(posedge clk) begin
    if (mem.a_rd_en) mem.a_rd_data <= mem_a[mem.a_rd_addr];
    if (mem.b_rd_en) mem.b_rd_data <= mem_b[mem.b_rd_addr];
  end

  typedef struct {
    logic              pass;
    logic              tmo;
    logic              late;
    logic [CNT_W-1:0]  a_cnt;
    logic [CNT_W-1:0]  b_cnt;
    logic [CNT_W-1:0]  mm_cnt;
    logic [ADDR_W-1:0] mm_addr;
    logic [WIDTH-1:0]  mm_a;
    logic [WIDTH-1:0]  mm_b;
    int unsigned       lat;
    int unsigned       scan;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int unsigned t0 = 0;
  logic scan_seen;
  int unsigned scan_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input int unsigned n);
    return (n >= (2 ** CNT_W) - 1) ? '1 : CNT_W'(n);
  endfunction

  task automatic fill_same();
    for (int i = 0; i < SIZE; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = mem_a[i];
    end
  endtask

  // Expected outcome from the memory contents and the write pattern driven.
  task automatic push_exp(input int unsigned nmax, input int unsigned na, input int unsigned nb,
                          input logic late, input logic tmo);
    exp_t e;
    int unsigned cnt = 0;
    e.tmo = tmo; e.late = late;
    e.a_cnt = sat(na); e.b_cnt = sat(nb);
    e.mm_addr = '0; e.mm_a = '0; e.mm_b = '0;
    if (tmo) begin
      e.lat = MAX_CYCLES;
      e.scan = 0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (mem_a[i] !== mem_b[i]) begin
          if (cnt == 0) begin
            e.mm_addr = ADDR_W'(i); e.mm_a = mem_a[i]; e.mm_b = mem_b[i];
          end
          cnt++;
        end
      end
      e.scan = nmax + IDLE_TIMEOUT;
      e.lat = e.scan + SIZE + 1;
    end
    e.mm_cnt = sat(cnt);
    e.pass = (cnt == 0) && !tmo && !late;
    sb.push_back(e);
  endtask

  task automatic start();
    tstart = 1'b1;
    @(posedge clk); #1;
    tstart = 1'b0;
    t0 = cyc;
  endtask

  task automatic drive_writes(input int unsigned na, input int unsigned nb);
    int unsigned n = (na > nb) ? na : nb;
    for (int unsigned k = 0; k < n; k++) begin
      mem.a_wr_en = (k < na);
      mem.b_wr_en = (k < nb);
      @(posedge clk); #1;
    end
    mem.a_wr_en = 1'b0;
    mem.b_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int late_addr, output logic got, output int unsigned done_cyc);
    int unsigned exp_addr = 0;
    got = 1'b0;
    done_cyc = 0;
    scan_seen = 1'b0;
    scan_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem.a_rd_en) begin
        if (!scan_seen) begin
          scan_seen = 1'b1;
          scan_cyc = cyc - t0;
        end
        chk("a_rd_addr", mem.a_rd_addr, exp_addr);
        chk("b_rd_addr", mem.b_rd_addr, exp_addr);
        exp_addr++;
      end
      if (late_addr >= 0)
        mem.b_wr_en = mem.a_rd_en && (int'(mem.a_rd_addr) == late_addr);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc - t0;
        break;
      end
    end
    mem.b_wr_en = 1'b0;
  endtask

  task automatic check_result(input logic got, input int unsigned done_cyc);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("done_within_budget", got, 1'b1);
    if (!got) return;
    chk("done_latency", done_cyc, e.lat);
    if (e.tmo) chk("no_rd_en", scan_seen, 1'b0);
    else       chk("scan_start", scan_cyc, e.scan);
    chk("pass", pass, e.pass);
    chk("timeout", timeout, e.tmo);
    chk("late_write", late_write, e.late);
    chk("a_wr_cnt", a_wr_cnt, e.a_cnt);
    chk("b_wr_cnt", b_wr_cnt, e.b_cnt);
    chk("mismatch_cnt", mismatch_cnt, e.mm_cnt);
    chk("first_mm_addr", first_mm_addr, e.mm_addr);
    chk("first_mm_a", first_mm_a, e.mm_a);
    chk("first_mm_b", first_mm_b, e.mm_b);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1'b1);
    chk("pass_held", pass, e.pass);
    chk("mismatch_held", mismatch_cnt, e.mm_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic got;
    int unsigned dc;
    logic hit;

    mem.a_wr_en = 1'b0;
    mem.b_wr_en = 1'b0;
    fill_same();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rd_en", mem.a_rd_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_late", late_write, 1'b0);
    chk("rst_a_cnt", a_wr_cnt, 0);
    chk("rst_mm_cnt", mismatch_cnt, 0);
    chk("rst_first_mm_b", first_mm_b, 0);

    // 1: identical data, A writes 10x, B 12x; the tstart-cycle write is not counted.
    mem.a_wr_en = 1'b1;
    start();
    push_exp(12, 10, 12, 1'b0, 1'b0);
    drive_writes(10, 12);
    wait_done(-1, got, dc);
    check_result(got, dc);

    // 2: single difference at 32 (restart from DONE).
    fill_same();
    mem_a[32] = 32'd0;
    mem_b[32] = 32'd33;
    start();
    push_exp(3, 3, 0, 1'b0, 1'b0);
    drive_writes(3, 0);
    wait_done(-1, got, dc);
    check_result(got, dc);

    // 3: differences at 5 and 60, no writes at all.
    fill_same();
    mem_b[5]  = ~mem_a[5];
    mem_a[60] = mem_b[60] ^ 32'h8000_0000;
    start();
    push_exp(0, 0, 0, 1'b0, 1'b0);
    wait_done(-1, got, dc);
    check_result(got, dc);

    // 5: B writes during the scan at address 20.
    fill_same();
    start();
    push_exp(5, 0, 5, 1'b1, 1'b0);
    drive_writes(0, 5);
    wait_done(20, got, dc);
    check_result(got, dc);

    // Every word differs: mismatch count saturates, first mismatch at 0.
    fill_same();
    for (int i = 0; i < SIZE; i++) mem_b[i] = ~mem_a[i];
    start();
    push_exp(0, 0, 0, 1'b0, 1'b0);
    wait_done(-1, got, dc);
    check_result(got, dc);

    // 4: A never goes quiet -> watchdog, write count saturates.
    fill_same();
    mem.a_wr_en = 1'b1;
    start();
    push_exp(0, MAX_CYCLES, 0, 1'b0, 1'b1);
    wait_done(-1, got, dc);
    mem.a_wr_en = 1'b0;
    check_result(got, dc);

    // 6: reset in the middle of a scan, then rerun scenario 1.
    fill_same();
    start();
    drive_writes(10, 12);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem.a_rd_en && (mem.a_rd_addr == ADDR_W'(30))) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_scan_30", hit, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_rd_en", mem.a_rd_en, 1'b0);
    chk("midscan_rst_done", done, 1'b0);
    chk("midscan_rst_a_cnt", a_wr_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    start();
    push_exp(12, 10, 12, 1'b0, 1'b0);
    drive_writes(10, 12);
    wait_done(-1, got, dc);
    check_result(got, dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
